// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe move generator.
//   - cell codes (EMPTY / X_MARK / O_MARK / BOTH_MARK) and winner codes
//   - LINE_TABLE: the 8 winning lines, three 1-based cell numbers per line
//   - state_t: move generator FSM states
//   - corner/edge search orders (fixed, and the rings rotated when the
//     MOVE_GEN_LFSR_EN build option is enabled in ttt_move_gen)
//   - firstEmpty(): first empty cell of a 4-entry search order
package ttt_pkg;

    localparam logic [1:0] EMPTY     = 2'b00;
    localparam logic [1:0] X_MARK    = 2'b01;
    localparam logic [1:0] O_MARK    = 2'b10;
    localparam logic [1:0] BOTH_MARK = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Entry [i] = {cellA, cellB, cellC}; cellA sits in bits [11:8].
    localparam logic [7:0][11:0] LINE_TABLE = {
        {4'd3, 4'd5, 4'd7},   // 7
        {4'd1, 4'd5, 4'd9},   // 6
        {4'd3, 4'd6, 4'd9},   // 5
        {4'd2, 4'd5, 4'd8},   // 4
        {4'd1, 4'd4, 4'd7},   // 3
        {4'd7, 4'd8, 4'd9},   // 2
        {4'd4, 4'd5, 4'd6},   // 1
        {4'd1, 4'd2, 4'd3}    // 0
    };

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WIN    = 3'd1,
        BLOCK  = 3'd2,
        CENTER = 3'd3,
        CORNER = 3'd4,
        EDGE   = 3'd5,
        EMIT   = 3'd6,
        REJECT = 3'd7
    } state_t;

    // Search orders, element [0] is tried first.
    localparam logic [3:0][3:0] CORNER_ORDER = {4'd9, 4'd7, 4'd3, 4'd1};
    localparam logic [3:0][3:0] EDGE_ORDER   = {4'd8, 4'd6, 4'd4, 4'd2};
    // Rings walked clockwise, rotated by the random offset when enabled.
    localparam logic [3:0][3:0] CORNER_RING  = {4'd7, 4'd9, 4'd3, 4'd1};
    localparam logic [3:0][3:0] EDGE_RING    = {4'd4, 4'd8, 4'd6, 4'd2};

    // Returns {found, cell}; lowest order position wins.
    function automatic logic [4:0] firstEmpty(input logic [9:1][1:0] b,
                                              input logic [3:0][3:0] order);
        logic [4:0] pick;
        pick = 5'd0;
        for (int k = 3; k >= 0; k--) begin
            if (b[order[k]] == EMPTY) pick = {1'b1, order[k]};
        end
        return pick;
    endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: combinational test of one board line for a given mark.
// Ports:
//   cellA/cellB/cellC  in   cell codes of the line, in line-table order
//   mark               in   mark being looked for
//   hit                out  exactly two cells equal mark and the third is EMPTY
//   offset             out  position of the empty cell (0=A, 1=B, 2=C); 0 when no hit
// BOTH_MARK counts as occupied and never equals a player mark.
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] cellA,
    input  logic [1:0] cellB,
    input  logic [1:0] cellC,
    input  logic [1:0] mark,
    output logic       hit,
    output logic [1:0] offset
);

    always_comb begin
        hit    = 1'b0;
        offset = 2'd0;
        if (cellA == mark && cellB == mark && cellC == EMPTY) begin
            hit    = 1'b1;
            offset = 2'd2;
        end else if (cellA == mark && cellC == mark && cellB == EMPTY) begin
            hit    = 1'b1;
            offset = 2'd1;
        end else if (cellB == mark && cellC == mark && cellA == EMPTY) begin
            hit    = 1'b1;
            offset = 2'd0;
        end
    end

endmodule

// File: rtl/ttt_move_gen.sv
// ttt_move_gen: automatic opponent. On req (sampled in IDLE) it captures the
// board and picks a move by priority win > block > centre > corner > edge,
// scanning one line per clock.
// Ports:
//   clk, reset         rising-edge clock, async active-high reset
//   req                one-cycle request, only looked at in IDLE
//   pos1..pos9         live board cells (00 empty, 01 X, 10 O, 11 occupied)
//   gameWinner         00 none, 01 X, 10 O, 11 draw
//   move_pos           chosen cell 1..9, holds between moves
//   move_valid         one-cycle pulse: move_pos carries a new move
//   no_move            one-cycle pulse: request rejected (game over / full)
//   busy               high whenever the FSM is not IDLE
//   dbgState           current FSM state
// Handshake: each accepted req produces exactly one move_valid or no_move
// pulse (never both); req seen while busy is dropped, not queued; a reset
// mid-scan aborts silently.
// Build option: MOVE_GEN_LFSR_EN randomises corner/edge order with an 8-bit
// LFSR rotation latched when the request is accepted.
module ttt_move_gen
    import ttt_pkg::*;
#(
    parameter logic [1:0] OWN_MARK = O_MARK,
    parameter logic [1:0] OPP_MARK = X_MARK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    input  logic [1:0] gameWinner,
    output logic [3:0] move_pos,
    output logic       move_valid,
    output logic       no_move,
    output logic       busy,
    output logic [2:0] dbgState
);

    state_t           state, stateNext;
    logic [2:0]       idx, idxNext;
    logic [3:0]       posNext;
    logic             capture;
    logic [9:1][1:0]  board, liveBoard;
    logic             boardFull;
    logic [11:0]      lineCells;
    logic [1:0]       scanMark, hitOffset;
    logic             lineHit;
    logic [3:0]       hitCell;
    logic [3:0][3:0]  cornerOrder, edgeOrder;
    logic [4:0]       cornerPick, edgePick;

    assign liveBoard = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

    always_comb begin
        boardFull = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (liveBoard[i] == EMPTY) boardFull = 1'b0;
        end
    end

    // One evaluator shared by WIN and BLOCK; the mark flips with the state.
    assign lineCells = LINE_TABLE[idx];
    assign scanMark  = (state == BLOCK) ? OPP_MARK : OWN_MARK;

    ttt_line_eval uLineEval (
        .cellA  (board[lineCells[11:8]]),
        .cellB  (board[lineCells[7:4]]),
        .cellC  (board[lineCells[3:0]]),
        .mark   (scanMark),
        .hit    (lineHit),
        .offset (hitOffset)
    );

    always_comb begin
        case (hitOffset)
            2'd0:    hitCell = lineCells[11:8];
            2'd1:    hitCell = lineCells[7:4];
            default: hitCell = lineCells[3:0];
        endcase
    end

`ifdef MOVE_GEN_LFSR_EN
    logic [7:0] lfsr;
    logic [1:0] rot;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so the rotation depends on
    // when the request arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 8'h01;
            rot  <= 2'd0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (capture) rot <= lfsr[1:0];
        end
    end

    always_comb begin
        cornerOrder = CORNER_RING;
        edgeOrder   = EDGE_RING;
        for (int k = 0; k < 4; k++) begin
            cornerOrder[k] = CORNER_RING[2'(k) + rot];
            edgeOrder[k]   = EDGE_RING[2'(k) + rot];
        end
    end
`else
    assign cornerOrder = CORNER_ORDER;
    assign edgeOrder   = EDGE_ORDER;
`endif

    assign cornerPick = firstEmpty(board, cornerOrder);
    assign edgePick   = firstEmpty(board, edgeOrder);

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        posNext   = move_pos;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (gameWinner != WIN_NONE || boardFull) begin
                        stateNext = REJECT;
                    end else begin
                        capture   = 1'b1;
                        idxNext   = 3'd0;
                        stateNext = WIN;
                    end
                end
            end
            WIN, BLOCK: begin
                if (lineHit) begin
                    posNext   = hitCell;
                    stateNext = EMIT;
                end else if (idx == 3'd7) begin
                    idxNext   = 3'd0;
                    stateNext = (state == WIN) ? BLOCK : CENTER;
                end else begin
                    idxNext = idx + 3'd1;
                end
            end
            CENTER: begin
                if (board[5] == EMPTY) begin
                    posNext   = 4'd5;
                    stateNext = EMIT;
                end else begin
                    stateNext = CORNER;
                end
            end
            CORNER: begin
                if (cornerPick[4]) begin
                    posNext   = cornerPick[3:0];
                    stateNext = EMIT;
                end else begin
                    stateNext = EDGE;
                end
            end
            EDGE: begin
                // A full board never gets here, so an edge is always free.
                if (edgePick[4]) posNext = edgePick[3:0];
                stateNext = EMIT;
            end
            EMIT:    stateNext = IDLE;
            REJECT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= 3'd0;
            move_pos <= 4'd0;
            board    <= '0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            move_pos <= posNext;
            if (capture) board <= liveBoard;
        end
    end

    assign move_valid = (state == EMIT);
    assign no_move    = (state == REJECT);
    assign busy       = (state != IDLE);
    assign dbgState   = state;

endmodule

// File: tb/tb_ttt_move_gen.sv
// Directed bench for ttt_move_gen: a driver issues requests and pushes the
// expected {reject, move_pos, latency} into exp_q; a negedge monitor pops and
// checks each move_valid / no_move pulse.
module tb_ttt_move_gen;

    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;
    localparam logic [1:0] B = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [1:0] cells [1:9];
    logic [1:0] gameWinner = 2'b00;
    logic [3:0] move_pos;
    logic       move_valid, no_move, busy;
    logic [2:0] dbgState;

    ttt_move_gen dut (
        .clk(clk), .reset(reset), .req(req),
        .pos1(cells[1]), .pos2(cells[2]), .pos3(cells[3]),
        .pos4(cells[4]), .pos5(cells[5]), .pos6(cells[6]),
        .pos7(cells[7]), .pos8(cells[8]), .pos9(cells[9]),
        .gameWinner(gameWinner),
        .move_pos(move_pos), .move_valid(move_valid), .no_move(no_move),
        .busy(busy), .dbgState(dbgState)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         e0Cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] exp_q[$];   // {isReject, move_pos[3:0], latency[4:0]}
    logic [3:0] lastPos = 4'd0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [9:0] e;
        int         lat;
        if (!reset && (move_valid || no_move)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, move_valid, no_move}, 32'd0);
            end else begin
                e   = exp_q.pop_front();
                lat = cyc - e0Cyc;
                check("pulse_kind", {30'd0, move_valid, no_move}, e[9] ? 32'd1 : 32'd2);
                check("move_pos", {28'd0, move_pos}, {28'd0, e[8:5]});
                if (e[9]) check("reject_latency_le1", {31'd0, lat <= 1}, 32'd1);
                else      check("move_latency", lat, {27'd0, e[4:0]});
            end
        end
    end

    // driver tasks
    task automatic setBoard(input logic [17:0] b);   // cell1 in MSBs
        for (int i = 1; i <= 9; i++) cells[i] = b[(9-i)*2 +: 2];
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 40; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("response_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic startReq();
        req = 1'b1;
        @(posedge clk);
        #1 e0Cyc = cyc;
        req = 1'b0;
    endtask

    task automatic issue(input logic [17:0] b, input logic [1:0] winner,
                         input logic isReject, input logic [3:0] pos, input logic [4:0] lat);
        @(negedge clk);
        setBoard(b);
        gameWinner = winner;
        exp_q.push_back({isReject, isReject ? lastPos : pos, lat});
        if (!isReject) lastPos = pos;
        startReq();
        waitDrain();
    endtask

    initial begin
        setBoard(18'd0);
        repeat (3) @(negedge clk);
        check("reset_move_pos", {28'd0, move_pos}, 32'd0);
        check("reset_move_valid", {31'd0, move_valid}, 32'd0);
        check("reset_no_move", {31'd0, no_move}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue({N,N,N, N,N,N, N,N,N}, 2'b00, 1'b0, 4'd5, 5'd17);  // centre
        issue({O,N,N, N,X,N, X,N,N}, 2'b00, 1'b0, 4'd3, 5'd16);  // block line 7
        issue({O,O,N, N,X,N, N,N,X}, 2'b00, 1'b0, 4'd3, 5'd1);   // win line 0
        issue({O,N,N, N,X,N, X,N,N}, 2'b01, 1'b1, 4'd0, 5'd0);   // X already won
        issue({X,O,X, X,O,O, O,X,B}, 2'b00, 1'b1, 4'd0, 5'd0);   // full board
        issue({N,N,N, N,X,N, N,N,N}, 2'b00, 1'b0, 4'd1, 5'd18);  // corner
        issue({X,N,O, N,B,N, O,N,X}, 2'b00, 1'b0, 4'd2, 5'd19);  // edge 2
        issue({X,B,O, N,B,N, O,N,X}, 2'b00, 1'b0, 4'd4, 5'd19);  // edge 4
        issue({X,X,N, O,N,O, N,N,N}, 2'b00, 1'b0, 4'd5, 5'd2);   // win beats block
        issue({X,N,N, X,O,N, N,N,N}, 2'b00, 1'b0, 4'd7, 5'd12);  // block line 3
        issue({X,N,O, N,O,N, N,N,N}, 2'b00, 1'b0, 4'd7, 5'd8);   // win line 7

        // Extra reqs and board edits during the scan must not matter.
        @(negedge clk);
        setBoard(18'd0);
        gameWinner = 2'b00;
        exp_q.push_back({1'b0, 4'd5, 5'd17});
        lastPos = 4'd5;
        startReq();
        @(negedge clk); req = 1'b1; cells[5] = X; cells[2] = O; cells[3] = O;
        @(negedge clk); req = 1'b0;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        repeat (12) @(negedge clk);
        req = 1'b1;
        @(negedge clk); req = 1'b0;
        waitDrain();

        // Reset in the middle of a scan aborts silently.
        @(negedge clk);
        setBoard(18'd0);
        startReq();
        repeat (5) @(posedge clk);
        #1 check("busy_during_scan", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_move_pos", {28'd0, move_pos}, 32'd0);
        check("abort_move_valid", {31'd0, move_valid}, 32'd0);
        check("abort_no_move", {31'd0, no_move}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lastPos = 4'd0;
        repeat (25) @(negedge clk);

        issue({N,N,N, N,O,N, N,N,N}, 2'b00, 1'b0, 4'd1, 5'd18);  // served after abort
        issue({N,N,N, N,O,N, N,N,N}, 2'b10, 1'b1, 4'd0, 5'd0);   // O won: pos holds

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ttt_move_gen.md
Name: ttt_move_gen

Overview:
Automatic opponent for the tic-tac-toe game core. It reads the board cells pos1..pos9 and the winner code, and returns one legal move position. The move is meant to drive the game's oPlayerPos input, together with a strobe the top level turns into play.
The block is sequential: on request it captures the board, then scans the 8 lines one per clock using the priority win > block > centre > corner > edge.

Parameters:
OWN_MARK, 2'b10, cell code of the mark this block plays (O).
OPP_MARK, 2'b01, cell code of the opponent mark (X).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  1  single-cycle move request; sampled only in IDLE
pos1..pos9  input  2 each  live board cells: 00 empty, 01 X, 10 O, 11 occupied/neither
gameWinner  input  2  00 none, 01 X, 10 O, 11 draw
move_pos  output  4  chosen cell, 1..9; holds last value between moves
move_valid  output  1  one-cycle pulse, move_pos valid
no_move  output  1  one-cycle pulse, request rejected
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state IDLE, move_pos=0, move_valid=0, no_move=0, busy=0, scan index=0. No pulse is emitted for an aborted request.
- States: IDLE, WIN, BLOCK, CENTER, CORNER, EDGE, EMIT, REJECT.
- Let E0 be the clock edge at which req=1 is sampled in IDLE.
- At E0, if gameWinner!=00 or all 9 cells are non-empty: go to REJECT. Otherwise capture the 9 cells into a board register, set idx=0 and go to WIN.
- Line table, idx 0..7: 1-2-3, 4-5-6, 7-8-9, 1-4-7, 2-5-8, 3-6-9, 1-5-9, 3-5-7.
- A line "hits" for mark M when exactly two of its cells equal M and the third is 00; the hit cell is that empty cell. Code 11 counts as occupied and matches neither mark.
- WIN: line idx is evaluated for OWN_MARK at edge E0+1+idx.
  - Hit: load move_pos and go to EMIT.
  - Miss at idx=7: go to BLOCK with idx=0.
  - Otherwise idx+1.
- BLOCK: same rule with OPP_MARK, evaluated at E0+9+idx. Miss at idx=7 goes to CENTER.
- CENTER (edge E0+17): if cell 5 is empty, move_pos=5 and go to EMIT; else go to CORNER.
- CORNER (E0+18): pick the first empty cell in order 1,3,7,9 and go to EMIT; else go to EDGE.
- EDGE (E0+19): pick the first empty cell in order 2,4,6,8 and go to EMIT.
  - EDGE always finds a cell, because a full board is rejected at E0.
- EMIT: move_valid=1 for exactly one cycle, then IDLE.
- REJECT: no_move=1 for one cycle, move_valid=0, move_pos unchanged, then IDLE.
- Latency from E0 to move_valid high:
  - win on line i: 1+i cycles
  - block on line j: 9+j cycles
  - centre: 17, corner: 18, edge: 19
  - worst case: 19
- req while busy: ignored, not queued.
- Board inputs changing during a scan: ignored; only the register captured at E0 is used.
- req may be asserted in the cycle EMIT returns to IDLE. It is sampled at that IDLE edge, so back-to-back service takes at least 1 IDLE cycle.

Optional Feature:
MOVE_GEN_LFSR_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01 on reset) advances every clock.
  - At E0, lfsr[1:0] is latched as a rotation r.
  - The corner order becomes the r-th rotation of 1,3,9,7 (r=0 gives 1,3,9,7).
  - Edge order rotates 2,6,8,4 by the same r.
  - Latency is unchanged.
- Undefined: fixed orders 1,3,7,9 and 2,4,6,8; no LFSR flops.

Decomposition:
- Package ttt_pkg holds:
  - cell codes EMPTY/X_MARK/O_MARK
  - winner codes
  - the 8x3 line table of cell indices
  - the state enum
  - corner and edge order constants
- One natural sub-module, ttt_line_eval: combinational; takes 3 cells and a mark, returns hit plus a 2-bit offset of the empty cell. It is instantiated once and muxed by idx.

Test Plan:
- Empty board, req -> move_valid at E0+17, move_pos=5.
- X at 5 and 7, O at 1, rest empty -> block on line 7 (3-5-7): move_valid at E0+16, move_pos=3.
- O at 1 and 2, X at 5 and 9 -> own win on line 0: move_valid at E0+1, move_pos=3. Win has priority over block.
- gameWinner=01 at req -> no_move pulse at E0+1, move_valid stays 0, move_pos unchanged. Same for a full board with gameWinner=00.
- Extra req pulses during a scan -> exactly one move_valid. Cells changed after E0 do not alter move_pos.
- reset asserted at E0+5 -> outputs 0 and busy 0 immediately (asynchronous). No move_valid follows; the next req is served normally.
